// File: rtl/multdiv_issue_if.sv
// Issue-side bundle for the mult/div issue stage.
// slave  : the issue stage (multdiv_issue). It receives the decoded
//          instruction, flush and the multdiv response, and drives the
//          multdiv operands/start pulses, stall and writeback.
// master : the surrounding pipeline and multdiv unit (the reverse directions).
interface multdiv_issue_if;
   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;

   // Decoded instruction from the pipeline
   logic          issue_valid;
   logic          issue_is_div;
   logic [DW-1:0] issue_opA;
   logic [DW-1:0] issue_opB;
   logic [RW-1:0] issue_rd;
   logic          flush;

   // Response from the multdiv unit
   logic [DW-1:0] md_result;
   logic          md_exception;
   logic          md_resultRDY;

   // Request to the multdiv unit
   logic [DW-1:0] md_operandA;
   logic [DW-1:0] md_operandB;
   logic          md_ctrl_MULT;
   logic          md_ctrl_DIV;

   // Pipeline control and writeback
   logic          stall;
   logic          wb_valid;
   logic [RW-1:0] wb_rd;
   logic [DW-1:0] wb_data;
   logic          wb_exception;

   modport slave (
      input  issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
      input  md_result, md_exception, md_resultRDY,
      output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
      output stall, wb_valid, wb_rd, wb_data, wb_exception
   );

   modport master (
      output issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
      output md_result, md_exception, md_resultRDY,
      input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
      input  stall, wb_valid, wb_rd, wb_data, wb_exception
   );
endinterface

// File: rtl/multdiv_issue.sv
// Issue stage for a multi-cycle mult/div unit.
// Latches one decoded mult/div instruction, pulses the multdiv start line for
// one cycle, waits (bounded by TIMEOUT) for the result, then produces a single
// writeback cycle. Exceptions (reported or timeout) write an rstatus code to
// REG_RSTATUS instead of the result.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : multdiv_issue_if.slave (issue, flush, multdiv req/resp,
//             stall and writeback)
module multdiv_issue #(
   parameter int unsigned TIMEOUT     = 40,
   parameter int unsigned REG_RSTATUS = 30,
   parameter int unsigned EXC_MUL     = 4,
   parameter int unsigned EXC_DIV     = 5
) (
   input  logic           clock,
   input  logic           reset_n,
   multdiv_issue_if.slave bus
);

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned CW = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] opa_q, opa_d;
   logic [DW-1:0] opb_q, opb_d;
   logic [RW-1:0] rd_q, rd_d;
   logic          div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] res_q, res_d;
   logic          exc_q, exc_d;

   // State and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         rd_q    <= '0;
         div_q   <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         rd_q    <= rd_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      rd_d    = rd_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      exc_d   = exc_q;

      case (state_q)
         IDLE: begin
            // flush outranks a simultaneous issue; nothing is latched then
            if (bus.issue_valid && !bus.flush) begin
               opa_d   = bus.issue_opA;
               opb_d   = bus.issue_opB;
               rd_d    = bus.issue_rd;
               div_d   = bus.issue_is_div;
               state_d = START;
            end
         end
         START: begin
            // any resultRDY seen here belongs to an older operation
            cnt_d   = '0;
            state_d = bus.flush ? IDLE : WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (bus.flush) begin
               state_d = IDLE;
            end else if (bus.md_resultRDY) begin
               // a real result wins over a timeout in the same cycle
               res_d   = bus.md_result;
               exc_d   = bus.md_exception;
               state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               res_d   = '0;
               exc_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode
   always_comb begin
      bus.md_operandA  = opa_q;
      bus.md_operandB  = opb_q;
      bus.md_ctrl_MULT = (state_q == START) && !div_q;
      bus.md_ctrl_DIV  = (state_q == START) &&  div_q;
      bus.stall        = (state_q == START) || (state_q == WAIT) ||
                         ((state_q == IDLE) && bus.issue_valid && !bus.flush);
      bus.wb_valid     = 1'b0;
      bus.wb_rd        = '0;
      bus.wb_data      = '0;
      bus.wb_exception = 1'b0;

      // Writeback fields stay zero unless the strobe is actually raised
      if ((state_q == DONE) && !bus.flush) begin
         if (exc_q) begin
            bus.wb_valid     = 1'b1;
            bus.wb_rd        = RW'(REG_RSTATUS);
            bus.wb_data      = div_q ? DW'(EXC_DIV) : DW'(EXC_MUL);
            bus.wb_exception = 1'b1;
         end else if (rd_q != '0) begin
            bus.wb_valid     = 1'b1;
            bus.wb_rd        = rd_q;
            bus.wb_data      = res_q;
         end
      end
   end

endmodule

// File: tb/tb_multdiv_issue.sv
// Self-checking bench for multdiv_issue: directed vector table, hand-written
// flush/reset sequences and random operations against a cycle-level model.
module tb_multdiv_issue;

   localparam int TO      = 40;
   localparam int REG_RS  = 30;
   localparam int NEVER   = 1000;

   logic clock = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] last_a = '0;

   multdiv_issue_if bus();

   multdiv_issue #(
      .TIMEOUT(TO), .REG_RSTATUS(REG_RS), .EXC_MUL(4), .EXC_DIV(5)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // k: RDY presented k cycles after the start-pulse cycle (0 = never)
   // flush_at: cycle index after the issue cycle at which flush is raised (0 = none)
   typedef struct {
      bit          is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          k;
      logic [31:0] res;
      bit          exc;
      int          flush_at;
      bit          e_valid;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      bit          e_exc;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int k, input logic [31:0] res,
                               input bit exc, input int flush_at, input bit e_valid,
                               input logic [4:0] e_rd, input logic [31:0] e_data, input bit e_exc);
      vec_t v;
      v.is_div = is_div; v.a = a; v.b = b; v.rd = rd; v.k = k; v.res = res; v.exc = exc;
      v.flush_at = flush_at; v.e_valid = e_valid; v.e_rd = e_rd; v.e_data = e_data;
      v.e_exc = e_exc;
      return v;
   endfunction

   // Cycle index (issue cycle = 0) at which the DONE cycle would occur
   function automatic int done_cycle(input int k);
      int r;
      int last_wait;
      r         = (k > 0) ? 1 + k : NEVER;
      last_wait = 1 + TO;
      return ((r < last_wait) ? r : last_wait) + 1;
   endfunction

   // Reference outcome of one operation from the behavioural rules
   function automatic vec_t model(input vec_t v);
      vec_t o;
      bit   timed_out;
      bit   exc;
      bit   flushed;
      int   d;
      o         = v;
      d         = done_cycle(v.k);
      timed_out = (v.k == 0) || (1 + v.k > 1 + TO);
      exc       = timed_out ? 1'b1 : v.exc;
      flushed   = (v.flush_at >= 1) && (v.flush_at <= d);
      o.e_valid = 1'b0; o.e_rd = '0; o.e_data = '0; o.e_exc = 1'b0;
      if (!flushed) begin
         if (exc) begin
            o.e_valid = 1'b1; o.e_rd = 5'(REG_RS);
            o.e_data  = v.is_div ? 32'd5 : 32'd4; o.e_exc = 1'b1;
         end else if (v.rd != 5'd0) begin
            o.e_valid = 1'b1; o.e_rd = v.rd; o.e_data = v.res;
         end
      end
      return o;
   endfunction

   task automatic idle_inputs();
      bus.issue_valid = 1'b0; bus.issue_is_div = 1'b0; bus.issue_opA = '0; bus.issue_opB = '0;
      bus.issue_rd = '0; bus.flush = 1'b0; bus.md_result = '0; bus.md_exception = 1'b0;
      bus.md_resultRDY = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " opA"},   bus.md_operandA, 32'd0);
      chk({tag, " opB"},   bus.md_operandB, 32'd0);
      chk({tag, " mult"},  32'(bus.md_ctrl_MULT), 32'd0);
      chk({tag, " div"},   32'(bus.md_ctrl_DIV), 32'd0);
      chk({tag, " stall"}, 32'(bus.stall), 32'd0);
      chk({tag, " wbv"},   32'(bus.wb_valid), 32'd0);
      chk({tag, " wbrd"},  32'(bus.wb_rd), 32'd0);
      chk({tag, " wbd"},   bus.wb_data, 32'd0);
      chk({tag, " wbe"},   32'(bus.wb_exception), 32'd0);
   endtask

   // Run one operation cycle by cycle; inputs driven at negedge, outputs checked 1ns later
   task automatic do_op(input string id, input vec_t v);
      int  r, d, busy_last, end_c;
      bit  flushed_early, noise, is_wb;
      r             = (v.k > 0) ? 1 + v.k : NEVER;
      d             = done_cycle(v.k);
      flushed_early = (v.flush_at >= 1) && (v.flush_at < d);
      busy_last     = flushed_early ? v.flush_at : d - 1;
      if (flushed_early) end_c = (r < NEVER && r + 1 > v.flush_at + 1) ? r + 1 : v.flush_at + 1;
      else               end_c = d + 1;

      @(negedge clock);
      idle_inputs();
      bus.issue_valid = 1'b1; bus.issue_is_div = v.is_div; bus.issue_opA = v.a;
      bus.issue_opB = v.b; bus.issue_rd = v.rd;
      #1;
      chk($sformatf("%s issue stall", id), 32'(bus.stall), 32'd1);
      chk($sformatf("%s issue wbv", id), 32'(bus.wb_valid), 32'd0);
      last_a = v.a;

      for (int c = 1; c <= end_c; c++) begin
         @(negedge clock);
         noise = (c <= busy_last) || (!flushed_early && c == d);
         bus.issue_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.issue_is_div = 1'($urandom_range(0, 1));
         bus.issue_opA    = $urandom;
         bus.issue_opB    = $urandom;
         bus.issue_rd     = 5'($urandom);
         bus.flush        = (c == v.flush_at);
         // c==1 is the START cycle: a stale RDY there must be ignored
         bus.md_resultRDY = (c == 1) || (c == r);
         bus.md_result    = (c == r) ? v.res : $urandom;
         bus.md_exception = (c == r) ? v.exc : 1'($urandom_range(0, 1));
         #1;
         chk($sformatf("%s stall c%0d", id, c), 32'(bus.stall), 32'(c <= busy_last));
         chk($sformatf("%s mult c%0d", id, c), 32'(bus.md_ctrl_MULT), 32'(c == 1 && !v.is_div));
         chk($sformatf("%s div c%0d", id, c), 32'(bus.md_ctrl_DIV), 32'(c == 1 && v.is_div));
         if (c <= busy_last) begin
            chk($sformatf("%s opA c%0d", id, c), bus.md_operandA, v.a);
            chk($sformatf("%s opB c%0d", id, c), bus.md_operandB, v.b);
         end
         is_wb = !flushed_early && (c == d);
         chk($sformatf("%s wbv c%0d", id, c), 32'(bus.wb_valid), is_wb ? 32'(v.e_valid) : 32'd0);
         chk($sformatf("%s wbrd c%0d", id, c), 32'(bus.wb_rd), is_wb ? 32'(v.e_rd) : 32'd0);
         chk($sformatf("%s wbd c%0d", id, c), bus.wb_data, is_wb ? v.e_data : 32'd0);
         chk($sformatf("%s wbe c%0d", id, c), 32'(bus.wb_exception), is_wb ? 32'(v.e_exc) : 32'd0);
      end
      @(negedge clock);
      idle_inputs();
   endtask

   initial begin
      vec_t tbl[12];
      vec_t v;

      // 1 mult 7*6 rd3, 2 div-by-zero, 3 timeout, 4 flush in WAIT cycle 5 with late RDY,
      // 5 rd0, 6 RDY coincides with timeout, 7 RDY one cycle late -> timeout,
      // 8 flush in START, 9 flush in DONE, 10 fastest div, 11 rd0 with exception, 12 all-ones
      tbl[0]  = mk(0, 32'd7,   32'd6, 5'd3,  17, 32'd42, 0, 0, 1, 5'd3,  32'd42, 0);
      tbl[1]  = mk(1, 32'd10,  32'd0, 5'd4,  33, 32'd0,  1, 0, 1, 5'd30, 32'd5,  1);
      tbl[2]  = mk(0, 32'd5,   32'd5, 5'd9,  0,  32'd0,  0, 0, 1, 5'd30, 32'd4,  1);
      tbl[3]  = mk(0, 32'd7,   32'd8, 5'd3,  16, 32'd56, 0, 6, 0, 5'd0,  32'd0,  0);
      tbl[4]  = mk(0, 32'd3,   32'd3, 5'd0,  4,  32'd9,  0, 0, 0, 5'd0,  32'd0,  0);
      tbl[5]  = mk(0, 32'd11,  32'd7, 5'd7,  40, 32'd77, 0, 0, 1, 5'd7,  32'd77, 0);
      tbl[6]  = mk(1, 32'd12,  32'd4, 5'd2,  41, 32'd3,  0, 0, 1, 5'd30, 32'd5,  1);
      tbl[7]  = mk(0, 32'd2,   32'd2, 5'd8,  5,  32'd4,  0, 1, 0, 5'd0,  32'd0,  0);
      tbl[8]  = mk(1, 32'd9,   32'd3, 5'd6,  3,  32'd3,  0, 5, 0, 5'd0,  32'd0,  0);
      tbl[9]  = mk(1, 32'd100, 32'd7, 5'd31, 1,  32'd14, 0, 0, 1, 5'd31, 32'd14, 0);
      tbl[10] = mk(0, 32'd1,   32'd1, 5'd0,  2,  32'd1,  1, 0, 1, 5'd30, 32'd4,  1);
      tbl[11] = mk(0, 32'hFFFF_FFFF, 32'd1, 5'd5, 1, 32'hFFFF_FFFF, 0, 0, 1, 5'd5, 32'hFFFF_FFFF, 0);

      idle_inputs();
      reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #1;
      chk_all_zero("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) do_op($sformatf("vec%0d", i), tbl[i]);

      // flush in IDLE outranks issue: no stall, nothing latched
      @(negedge clock);
      bus.issue_valid = 1'b1; bus.flush = 1'b1; bus.issue_opA = 32'h1234_5678;
      bus.issue_opB = 32'h9; bus.issue_rd = 5'd1;
      #1;
      chk("idleflush stall", 32'(bus.stall), 32'd0);
      @(negedge clock);
      idle_inputs();
      #1;
      chk("idleflush stall2", 32'(bus.stall), 32'd0);
      chk("idleflush mult", 32'(bus.md_ctrl_MULT), 32'd0);
      chk("idleflush opA", bus.md_operandA, last_a);

      // reset in the middle of WAIT
      @(negedge clock);
      bus.issue_valid = 1'b1; bus.issue_opA = 32'd11; bus.issue_opB = 32'd13; bus.issue_rd = 5'd6;
      @(negedge clock);
      idle_inputs();
      repeat (4) @(negedge clock);
      #1;
      chk("prereset stall", 32'(bus.stall), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clock);
      bus.md_resultRDY = 1'b1; bus.md_result = 32'd99;
      #1;
      chk_all_zero("inreset");
      @(negedge clock);
      reset_n = 1'b1;
      bus.md_resultRDY = 1'b1; bus.md_result = 32'd143;
      #1;
      chk_all_zero("release");
      @(negedge clock);
      idle_inputs();
      #1;
      chk_all_zero("postrelease");
      do_op("post3x3", mk(0, 32'd3, 32'd3, 5'd1, 5, 32'd9, 0, 0, 1, 5'd1, 32'd9, 0));

      // random operations against the model
      for (int n = 0; n < 40; n++) begin
         v.is_div = 1'($urandom_range(0, 1));
         v.a      = $urandom;
         v.b      = $urandom;
         v.rd     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         v.k      = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 44));
         v.res    = $urandom;
         v.exc    = ($urandom_range(0, 3) == 0);
         v.flush_at = 0;
         if ($urandom_range(0, 3) == 0) v.flush_at = int'($urandom_range(1, done_cycle(v.k)));
         do_op($sformatf("rnd%0d", n), model(v));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
